hashfunc_unit: RTL and testbench

HASHFUNC_UNIT -- requirements
Module: hashfunc

---
 rtl/hash_pkg.sv | 20 ++
 rtl/mod_serial.sv | 43 ++++
 rtl/hashfunc_unit.sv | 104 ++++++++++
 tb/tb_hashfunc_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared sizing, iteration count and state encoding for the hash blocks
package hash_pkg;

    localparam int unsigned H1_SIZE_DEF = 5;
    localparam int unsigned H2_SIZE_DEF = 10;
    localparam int unsigned MODULUS_DEF = H1_SIZE_DEF * H2_SIZE_DEF;
    localparam int unsigned N_ITER      = 32;
    localparam int unsigned CNT_W       = $clog2(N_ITER + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Remainder register must hold 2*modulus-1 just before the conditional subtract.
    function automatic int unsigned rem_width(input int unsigned modulus);
        return $clog2(2 * modulus);
    endfunction

endpackage

// File: rtl/mod_serial.sv
// rtl/mod_serial.sv - bit-serial restoring remainder by a constant modulus, MSB first
module mod_serial #(
    parameter int unsigned MODULUS = 50,
    parameter int unsigned WIDTH   = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH:0]   shifted;

    // rem_q < MODULUS always holds, so one subtract restores the invariant.
    always_comb begin
        shifted = {rem_q, bit_i};
        rem_d   = rem_q;
        if (start_i) begin
            rem_d = '0;
        end else if (step_i) begin
            if (shifted >= (WIDTH+1)'(MODULUS)) begin
                rem_d = WIDTH'(shifted - (WIDTH+1)'(MODULUS));
            end else begin
                rem_d = WIDTH'(shifted);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/hashfunc_unit.sv
// rtl/hashfunc_unit.sv - two-table hash indices from one key via a serial remainder
module hashfunc_unit
    import hash_pkg::*;
#(
    parameter int unsigned H1_SIZE = H1_SIZE_DEF,
    parameter int unsigned H2_SIZE = H2_SIZE_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [31:0] key,
    output logic        ready,
    output logic        hash_valid,
    output logic [31:0] hash1,
    output logic [31:0] hash2
);

    localparam int unsigned MODULUS = H1_SIZE * H2_SIZE;
    localparam int unsigned REM_W   = rem_width(MODULUS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      key_q, key_d;
    logic [31:0]      hash1_q, hash1_d;
    logic [31:0]      hash2_q, hash2_d;
    logic             valid_q, valid_d;
    logic             start;
    logic             step;
    logic [REM_W-1:0] rem;
    logic [31:0]      r_ext;

    mod_serial #(
        .MODULUS (MODULUS),
        .WIDTH   (REM_W)
    ) u_mod (
        .clock   (clock),
        .reset_n (reset_n),
        .start_i (start),
        .step_i  (step),
        .bit_i   (key_q[31]),
        .rem_o   (rem)
    );

    assign r_ext = {{(32-REM_W){1'b0}}, rem};

    // The key is shifted left each step so its MSB always feeds the remainder.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        hash1_d = hash1_q;
        hash2_d = hash2_q;
        valid_d = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_BUSY;
                    key_d   = key;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q < CNT_W'(N_ITER)) begin
                    step  = 1'b1;
                    key_d = {key_q[30:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    hash1_d = r_ext % 32'(H1_SIZE);
                    hash2_d = r_ext / 32'(H1_SIZE);
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            hash1_q <= '0;
            hash2_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            hash1_q <= hash1_d;
            hash2_q <= hash2_d;
            valid_q <= valid_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign hash_valid = valid_q;
    assign hash1      = hash1_q;
    assign hash2      = hash2_q;

endmodule

// File: tb/tb_hashfunc_unit.sv
// tb/tb_hashfunc_unit.sv - scoreboard bench for hashfunc_unit
module tb_hashfunc_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [31:0] key = '0;
    logic        ready;
    logic        hash_valid;
    logic [31:0] hash1;
    logic [31:0] hash2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int vcount    = 0;

    typedef struct {
        logic [31:0] h1;
        logic [31:0] h2;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    hashfunc_unit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key        (key),
        .ready      (ready),
        .hash_valid (hash_valid),
        .hash1      (hash1),
        .hash2      (hash2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && hash_valid) begin
            exp_t e;
            vcount++;
            if (exp_q.size() == 0) begin
                check("unexpected_hash_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("hash1", hash1, e.h1);
                check("hash2", hash2, e.h2);
                check("latency", 32'(cyc - e.acc), 32'd33);
            end
        end
    end

    task automatic send(input logic [31:0] k, input logic [31:0] e1, input logic [31:0] e2,
                        input bit push, output bit offered_in_valid);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clock);
        while (!ready && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("ready_before_offer", {31'd0, ready}, 32'd1);
        offered_in_valid = hash_valid;
        key_valid = 1'b1;
        key       = k;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        key       = $urandom;
        if (push) begin
            e.h1  = e1;
            e.h2  = e2;
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        bit          inv;
        logic [31:0] k;
        int          vsnap;
        int          waited;

        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_hash_valid", {31'd0, hash_valid}, 32'd0);
        check("rst_hash1", hash1, 32'd0);
        check("rst_hash2", hash2, 32'd0);
        reset_n = 1'b1;

        send(32'd123,        32'd3, 32'd4, 1'b1, inv);
        send(32'hFFFF_FFFF,  32'd0, 32'd9, 1'b1, inv);
        send(32'd0,          32'd0, 32'd0, 1'b1, inv);
        send(32'd49,         32'd4, 32'd9, 1'b1, inv);
        send(32'd50,         32'd0, 32'd0, 1'b1, inv);

        // key_valid toggling with key=7 while busy must be ignored
        send(32'd123, 32'd3, 32'd4, 1'b1, inv);
        for (int i = 0; i < 33; i++) begin
            @(negedge clock);
            check("busy_ready_low", {31'd0, ready}, 32'd0);
            key       = 32'd7;
            key_valid = (i < 32) ? ~key_valid : 1'b0;
        end

        // back-to-back: 50 is offered in the hash_valid cycle of 123
        send(32'd123, 32'd3, 32'd4, 1'b1, inv);
        send(32'd50,  32'd0, 32'd0, 1'b1, inv);
        check("b2b_offer_in_valid_cycle", {31'd0, inv}, 32'd1);

        // abort by reset during busy
        send(32'd123, 32'd3, 32'd4, 1'b0, inv);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        vsnap = vcount;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_hash_valid", {31'd0, hash_valid}, 32'd0);
        check("abort_hash1", hash1, 32'd0);
        check("abort_hash2", hash2, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_valid", 32'(vcount - vsnap), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            k = $urandom;
            send(k, k % 32'd5, (k / 32'd5) % 32'd10, 1'b1, inv);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
